checksum_accumulator: RTL
=========================

# checksum_accumulator

Accumulates the four weighted ABFT checksums (w, x, y, z) over one output block of the systolic array. It consumes one result row per valid beat and emits registered checksum words with a one-cycle `valid_acc` strobe. It is the producer that feeds the `*_acc` side of the error detector. The dot-product checksum path, computed from the input operands, is produced elsewhere and is out of scope.

## Interface
Parameters:
- `arraySize`, 4: array dimension; one block is `arraySize` rows of `arraySize` results.
- `inputBits`, 8: operand width of the array.
- `addressWidth`, `$clog2(arraySize)`: row/column index width.
- `dataWidth`, `2*inputBits+addressWidth`: width of one array result lane, unsigned.
- `accWidth`, `2*inputBits+3*arraySize`: checksum output width.

Ports:
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_row`  in  1  `row_data` holds a valid result row this cycle.
- `row_data`  in  `arraySize*dataWidth`  lane j = `row_data[j*dataWidth +: dataWidth]`, column index j.
- `w_acc`  out  `accWidth`  Σ_i Σ_j c[i][j].
- `x_acc`  out  `accWidth`  Σ_i Σ_j (j+1)·c[i][j].
- `y_acc`  out  `accWidth`  Σ_i (i+1)·Σ_j c[i][j].
- `z_acc`  out  `accWidth`  Σ_i Σ_j (i+1)(j+1)·c[i][j].
- `valid_acc`  out  1  one-cycle strobe: `*_acc` hold a completed block.

## Operation
- Row index i is the count of rows already accepted in the current block, from 0 to arraySize-1. It is held in a row counter of width `$clog2(arraySize+1)`.
- Per accepted row, the combinational terms are:
  - rs = Σ_j c_j.
  - rw = Σ_j (j+1)·c_j.
- Each term is zero-extended to `accWidth`.
- Internal accumulators update as follows:
  - aw += rs.
  - ax += rw.
  - ay += (i+1)·rs.
  - az += (i+1)·rw.
- All arithmetic is unsigned modulo 2^accWidth. Wrap-around is silent; there is no saturation and no overflow flag.
- FSM states:
  - IDLE: counter = 0, accumulators = 0. A `valid_row` moves the FSM to ACCUM with counter = 1, or straight to the final-row handling if arraySize = 1.
  - ACCUM: each `valid_row` increments the counter and updates the accumulators.
  - Final row (counter = arraySize-1 and `valid_row`): the final sums including this row load into `w/x/y/z_acc`. The accumulators and counter clear, and the FSM returns to IDLE.
- Cycles with `valid_row` = 0 leave all state unchanged. Gaps of any length inside a block are legal.
- `*_acc` hold their value until the next block completes. `valid_acc` is the only strobe.
- No backpressure: every valid row is accepted.

## Timing
- Reset values: `w_acc = x_acc = y_acc = z_acc = 0`, `valid_acc = 0`, FSM = IDLE, counter = 0, accumulators = 0.
- Latency: `valid_acc` is high in the cycle immediately after the cycle carrying the last row of a block, and `*_acc` are valid in that same cycle.
- `valid_acc` lasts exactly one cycle per block.
- Back-to-back blocks: row 0 of block n+1 may arrive in the cycle directly after the last row of block n. It is accumulated from zero, with no loss and no bubble. `valid_acc` for block n is high in the cycle row 0 of block n+1 is presented.
- Reset during a block: the partial block is discarded and no `valid_acc` is issued for it. `*_acc` return to 0.
- `rst` together with `valid_row` in the same cycle: reset wins and the row is dropped.
- `valid_acc` never asserts without `arraySize` accepted rows since the last block boundary or reset.

## Test plan
Defaults throughout: arraySize = 4, dataWidth = 18, accWidth = 28.
- All ones: four consecutive rows, every lane = 1 -> a single `valid_acc` pulse one cycle after row 3, with w = 16, x = 40, y = 40, z = 100.
- Single hit: c[2][3] = 5, all other lanes 0 -> w = 5, x = 20, y = 15, z = 60.
- Gaps: all-ones block with 0, 3, 1 idle cycles between rows -> same values as the all-ones case. `valid_acc` is exactly one cycle after the 4th valid row, and `*_acc` are unchanged afterwards.
- Maximum values: every lane = 2^18-1 -> w = 4194288, x = 10485720, y = 10485720, z = 26214300.
- Back-to-back blocks: the all-ones block immediately followed by the single-hit block, no idle cycle -> two `valid_acc` pulses 4 cycles apart, with values 16/40/40/100 then 5/20/15/60.
- Reset mid-block: 2 rows of 7s, then `rst` for 1 cycle, then the all-ones block -> outputs are 0 after reset. `valid_acc` fires once, carrying 16/40/40/100.

Source files
------------

// File: rtl/checksum_accumulator.sv
// Accumulates the w/x/y/z weighted checksums of one arraySize x arraySize result block
// and presents them with a one-cycle valid_acc strobe after the final row.
// state | meaning
// IDLE  | no rows of the current block accepted yet, accumulators are zero
// ACCUM | 1..arraySize-1 rows of the current block accepted
module checksum_accumulator #(
  parameter int arraySize    = 4,
  parameter int inputBits    = 8,
  parameter int addressWidth = $clog2(arraySize),
  parameter int dataWidth    = 2*inputBits+addressWidth,
  parameter int accWidth     = 2*inputBits+3*arraySize
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_row,
  input  logic [arraySize*dataWidth-1:0] row_data,
  output logic [accWidth-1:0]           w_acc,
  output logic [accWidth-1:0]           x_acc,
  output logic [accWidth-1:0]           y_acc,
  output logic [accWidth-1:0]           z_acc,
  output logic                          valid_acc
);

  localparam int CntWidth = $clog2(arraySize+1);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [accWidth-1:0]   aw_q, aw_d, ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic [accWidth-1:0]   w_acc_q, w_acc_d, x_acc_q, x_acc_d;
  logic [accWidth-1:0]   y_acc_q, y_acc_d, z_acc_q, z_acc_d;
  logic                  valid_acc_q, valid_acc_d;

  logic [accWidth-1:0]   lane, rs, rw, row_mul;
  logic [accWidth-1:0]   sum_w, sum_x, sum_y, sum_z;
  logic                  last_row;

  always_comb begin
    lane = '0;
    rs   = '0;
    rw   = '0;
    for (int j = 0; j < arraySize; j++) begin
      lane = accWidth'(row_data[j*dataWidth +: dataWidth]);
      rs   = rs + lane;
      rw   = rw + lane * accWidth'(j+1);
    end
    // Row weight (i+1) comes straight from the count of rows already taken.
    row_mul  = accWidth'(cnt_q) + accWidth'(1);
    sum_w    = aw_q + rs;
    sum_x    = ax_q + rw;
    sum_y    = ay_q + row_mul * rs;
    sum_z    = az_q + row_mul * rw;
    last_row = valid_row && (cnt_q == CntWidth'(arraySize-1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aw_d        = aw_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    az_d        = az_q;
    w_acc_d     = w_acc_q;
    x_acc_d     = x_acc_q;
    y_acc_d     = y_acc_q;
    z_acc_d     = z_acc_q;
    valid_acc_d = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (last_row) begin
          // Final row covers arraySize = 1 too, where IDLE is also the last row.
          w_acc_d     = sum_w;
          x_acc_d     = sum_x;
          y_acc_d     = sum_y;
          z_acc_d     = sum_z;
          valid_acc_d = 1'b1;
          aw_d        = '0;
          ax_d        = '0;
          ay_d        = '0;
          az_d        = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (valid_row) begin
          aw_d    = sum_w;
          ax_d    = sum_x;
          ay_d    = sum_y;
          az_d    = sum_z;
          cnt_d   = cnt_q + CntWidth'(1);
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      aw_q        <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      az_q        <= '0;
      w_acc_q     <= '0;
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      z_acc_q     <= '0;
      valid_acc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aw_q        <= aw_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      az_q        <= az_d;
      w_acc_q     <= w_acc_d;
      x_acc_q     <= x_acc_d;
      y_acc_q     <= y_acc_d;
      z_acc_q     <= z_acc_d;
      valid_acc_q <= valid_acc_d;
    end
  end

  assign w_acc     = w_acc_q;
  assign x_acc     = x_acc_q;
  assign y_acc     = y_acc_q;
  assign z_acc     = z_acc_q;
  assign valid_acc = valid_acc_q;

endmodule
